// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - stall/flush sequencer for the five-stage LC-3b pipeline
module pipe_ctrl #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_resp,
  input  logic          dmem_access,
  input  logic          dmem_resp,
  input  logic          load_use,
  input  logic          mispredict,
  input  logic [15:0]   br_target,
  output logic          imem_read,
  output logic          load_pc,
  output logic          pc_sel,
  output logic [15:0]   redirect_pc,
  output logic          load_if_id,
  output logic          load_id_ex,
  output logic          load_ex_mem,
  output logic          load_mem_wb,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic [CW-1:0] stall_count,
  output logic [CW-1:0] flush_count
);

  // DISCARD: a fetch was in flight at a mispredict; let it finish, then drop it
  typedef enum logic {RUN, DISCARD} state_t;

  state_t      state, state_next;
  logic [15:0] redir_q;
  logic        dstall;
  logic        take_flush;

  assign dstall = dmem_access & ~dmem_resp;

  // Next-state and all pipeline-register controls, decoded from state and hazards
  always_comb begin
    state_next  = state;
    imem_read   = 1'b0;
    load_pc     = 1'b0;
    pc_sel      = 1'b0;
    redirect_pc = (state == DISCARD) ? redir_q : br_target;
    load_if_id  = 1'b0;
    load_id_ex  = 1'b0;
    load_ex_mem = 1'b0;
    load_mem_wb = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    take_flush  = 1'b0;
    if (reset) begin
      state_next = RUN;
    end else begin
      imem_read = 1'b1;
      case (state)
        RUN: begin
          if (dstall) begin
            // whole pipeline frozen; a mispredict will be seen again next cycle
          end else if (mispredict) begin
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            take_flush  = 1'b1;
            if (imem_resp) begin
              load_pc = 1'b1;
              pc_sel  = 1'b1;
            end else begin
              state_next = DISCARD;
            end
          end else if (load_use) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_id_ex = 1'b1;
          end else if (!imem_resp) begin
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_if_id = 1'b1;
          end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
          end
        end
        DISCARD: begin
          load_if_id  = ~dstall;
          load_id_ex  = ~dstall;
          load_ex_mem = ~dstall;
          load_mem_wb = ~dstall;
          flush_if_id = 1'b1;
          flush_id_ex = ~dstall;
          // the wrong-path word is dropped even if the back end is stalled
          if (imem_resp) begin
            load_pc    = 1'b1;
            pc_sel     = 1'b1;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // Hold the redirect target while the in-flight fetch drains
  always_ff @(posedge clk) begin
    if (reset)
      redir_q <= 16'h0000;
    else if (state == RUN && state_next == DISCARD)
      redir_q <= br_target;
  end

  // Saturating stall and flush performance counters
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!load_pc && stall_count != {CW{1'b1}})
        stall_count <= stall_count + 1'b1;
      if (take_flush && flush_count != {CW{1'b1}})
        flush_count <= flush_count + 1'b1;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the five-stage LC-3b pipeline. It sits beside the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and drives each register's load and flush inputs. Its inputs are the instruction-memory handshake, the data-memory handshake, load-use hazard detection and branch-mispredict resolution. It also holds a redirect target across an in-flight instruction fetch, and keeps stall and flush performance counters.

## Interface
- CW, 16, width of performance counters

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- imem_resp  in  1  instruction fetch for current PC completes this cycle
- dmem_access  in  1  instruction in MEM stage needs data memory
- dmem_resp  in  1  data memory access completes this cycle
- load_use  in  1  ID-stage instruction depends on a load in EX
- mispredict  in  1  branch in EX resolved against prediction; valid only when load_ex_mem=1
- br_target  in  16  correct PC for mispredicted branch (lc3b_word)
- imem_read  out  1  fetch request at current PC
- load_pc  out  1  PC register load enable
- pc_sel  out  1  1 = PC loads redirect_pc, 0 = normal next-PC
- redirect_pc  out  16  redirect target
- load_if_id, load_id_ex, load_ex_mem, load_mem_wb  out  1 each  pipeline register load enables
- flush_if_id, flush_id_ex  out  1 each  when set with the matching load, the register captures a NOP/bubble
- stall_count  out  CW  cycles in which the PC was held, excluding reset
- flush_count  out  CW  accepted mispredicts

## Operation
- dstall = dmem_access & ~dmem_resp.
- States are RUN and DISCARD. DISCARD means a fetch was in flight at a mispredict and must complete, then be dropped.
- RUN, priority order:
  1. dstall: every load_* = 0, every flush_* = 0, load_pc = 0. The whole pipeline freezes. mispredict is ignored.
  2. mispredict:
     - load_id_ex, load_ex_mem, load_mem_wb = 1.
     - load_if_id = 1 with flush_if_id = 1; flush_id_ex = 1.
     - If imem_resp = 1: load_pc = 1, pc_sel = 1, redirect_pc = br_target. Stay in RUN.
     - Otherwise: latch br_target into redir_q, load_pc = 0, go to DISCARD.
     - Increment flush_count.
  3. load_use:
     - load_pc = 0, load_if_id = 0 (hold).
     - load_id_ex = 1 with flush_id_ex = 1 (bubble).
     - load_ex_mem, load_mem_wb = 1.
  4. ~imem_resp:
     - load_pc = 0.
     - load_if_id = 1 with flush_if_id = 1 (bubble).
     - Downstream loads = 1.
  5. Otherwise: all loads = 1, flushes = 0, load_pc = 1, pc_sel = 0.
- DISCARD:
  - imem_read = 1 at the unchanged PC.
  - redirect_pc = redir_q. mispredict is ignored.
  - Downstream loads = ~dstall.
  - load_if_id = ~dstall with flush_if_id = 1; flush_id_ex = 1 whenever load_id_ex = 1.
  - When imem_resp = 1: load_pc = 1, pc_sel = 1, go to RUN. This happens regardless of dstall; the fetched word is dropped.
- imem_read = 1 in both states whenever reset = 0.
- Counters:
  - stall_count increments in any non-reset cycle with load_pc = 0.
  - flush_count increments per case-2 mispredict.
  - Both counters saturate at 2^CW-1.
- redir_q loads only on the RUN to DISCARD transition.

## Timing
- All control outputs except the counters and redirect_pc in DISCARD are combinational from inputs and state. They have zero-cycle latency and are consumed at the same rising edge.
- A redirect takes effect at the edge where load_pc = pc_sel = 1. The new PC is fetched in the next cycle.
- Minimum mispredict penalty is 2 bubbles (IF/ID and ID/EX). DISCARD adds one bubble per cycle until imem_resp.
- During reset = 1: all load_* = 0, flush_* = 0, imem_read = 0, load_pc = 0, pc_sel = 0.
  - After the edge: state = RUN, redir_q = 0, stall_count = 0, flush_count = 0.
  - Reset while in DISCARD abandons the redirect.
- Simultaneous events:
  - dstall dominates everything in RUN.
  - mispredict dominates load_use, because the dependent instruction is on the wrong path.
  - load_use with ~imem_resp: the load_use rule applies (IF/ID hold).
- Counter saturation: at 0xFFFF, stall_count holds, with no wrap.

## Test plan
- Reset, then steady imem_resp = 1 with no hazards:
  - All loads = 1, load_pc = 1, pc_sel = 0 every cycle.
  - stall_count = 0, flush_count = 0.
- dmem_access = 1 with dmem_resp low for 3 cycles, then high:
  - All loads = 0 for 3 cycles, then 1.
  - stall_count = 3.
- load_use for 1 cycle:
  - load_pc = 0, load_if_id = 0, load_id_ex = 1 with flush_id_ex = 1.
  - Next cycle, normal advance.
- mispredict with br_target = 0x3042 and imem_resp = 1:
  - load_pc = 1, pc_sel = 1, redirect_pc = 0x3042.
  - flush_if_id = 1, flush_id_ex = 1, flush_count = 1.
- mispredict with br_target = 0x1234 while imem_resp = 0, then imem_resp after 2 cycles, with br_target changed to 0xFFFF meanwhile:
  - DISCARD holds redirect_pc = 0x1234.
  - load_pc = 1, pc_sel = 1 on the resp cycle; back to RUN.
- In DISCARD, assert reset:
  - Next cycle: state RUN, load_pc = 1, pc_sel = 0, counters 0.
